mem_port_arbiter: RTL and testbench

Arbitrates one shared single-ported memory between the pipeline's instruction-fetch (IF) requester and data-memory (MEM stage) requester. It tracks a variable-latency valid/ready memory handshake and holds returned data for each requester. It produces the global `stall` that freezes all pipeline registers (`pipe_reg_en = ~stall`) until every active requester of the current cycle has been served.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/req_hold_slot.sv | 34 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the memory port arbiter
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IF_BUSY = 2'b01,
        DM_BUSY = 2'b10
    } arb_state_t;

endpackage

// File: rtl/req_hold_slot.sv
// rtl/req_hold_slot.sv - per-requester served flag and returned-data holding register
module req_hold_slot #(
    parameter int DATA_W = mem_arb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic              capture,
    input  logic [DATA_W-1:0] rdata_in,
    input  logic              adv,
    output logic              have,
    output logic [DATA_W-1:0] rdata
);

    // A completion landing on an advance edge wins; the flag clears on the following advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            have <= 1'b0;
        end else if (set) begin
            have <= 1'b1;
        end else if (adv) begin
            have <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (set && capture) begin
            rdata <= rdata_in;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data access, drives pipeline stall
module mem_port_arbiter #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_valid,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);
    import mem_arb_pkg::*;

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              load_if;
    logic              load_dm;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              if_have;
    logic              dm_have;
    logic              if_pend;
    logic              dm_pend;
    logic              busy;
    logic              if_set;
    logic              dm_set;

    assign if_pend = if_req & ~if_have;
    assign dm_pend = dm_req & ~dm_have;
    assign stall   = if_pend | dm_pend;
    assign busy    = (state_q != IDLE);
    assign if_set  = (state_q == IF_BUSY) & mem_ready;
    assign dm_set  = (state_q == DM_BUSY) & mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Data wins from IDLE since it belongs to the older instruction; on completion
    // the other requester is chained directly without an IDLE cycle.
    always_comb begin
        state_d = state_q;
        load_if = 1'b0;
        load_dm = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_pend) begin
                    state_d = DM_BUSY;
                    load_dm = 1'b1;
                end else if (if_pend) begin
                    state_d = IF_BUSY;
                    load_if = 1'b1;
                end
            end
            IF_BUSY: begin
                if (mem_ready) begin
                    if (dm_pend) begin
                        state_d = DM_BUSY;
                        load_dm = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DM_BUSY: begin
                if (mem_ready) begin
                    if (if_pend) begin
                        state_d = IF_BUSY;
                        load_if = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side request fields come only from these latches so requesters may change mid-transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (load_dm) begin
            addr_q  <= dm_addr;
            wr_q    <= dm_wr;
            wdata_q <= dm_wdata;
        end else if (load_if) begin
            addr_q  <= if_addr;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end
    end

    assign mem_valid = busy;
    assign mem_wr    = busy & wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    req_hold_slot #(.DATA_W(DATA_W)) u_if_slot (
        .clk      (clk),
        .reset    (reset),
        .set      (if_set),
        .capture  (1'b1),
        .rdata_in (mem_rdata),
        .adv      (~stall),
        .have     (if_have),
        .rdata    (if_rdata)
    );

    req_hold_slot #(.DATA_W(DATA_W)) u_dm_slot (
        .clk      (clk),
        .reset    (reset),
        .set      (dm_set),
        .capture  (~wr_q),
        .rdata_in (mem_rdata),
        .adv      (~stall),
        .have     (dm_have),
        .rdata    (dm_rdata)
    );

    assign if_done = if_have;
    assign dm_done = dm_have;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench with a transaction-level arbiter model
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req = 1'b0;
    logic        dm_wr = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_valid;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_req    (dm_req),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_valid (mem_valid),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which requester has been served this pipeline cycle, and which
    // transfer (if any) the memory is currently working on.
    bit          m_served_if = 0, m_served_dm = 0;
    logic [31:0] m_data_if = '0, m_data_dm = '0;
    bit          m_inflight = 0;
    int          m_owner = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    bit          m_wr = 0;

    always @(negedge clk) begin
        bit want_if, want_dm, frz, done_if, done_dm;
        if (!reset) begin
            m_served_if = 0; m_served_dm = 0;
            m_data_if = '0;  m_data_dm = '0;
            m_inflight = 0;  m_owner = 0;
            m_addr = '0; m_wdata = '0; m_wr = 0;
        end
        want_if = if_req && !m_served_if;
        want_dm = dm_req && !m_served_dm;
        frz = want_if || want_dm;
        check("stall", stall, frz);
        check("mem_valid", mem_valid, m_inflight);
        check("mem_wr", mem_wr, m_inflight && m_wr);
        if (m_inflight) begin
            check("mem_addr", mem_addr, m_addr);
            if (m_wr) check("mem_wdata", mem_wdata, m_wdata);
        end
        check("if_done", if_done, m_served_if);
        check("dm_done", dm_done, m_served_dm);
        check("if_rdata", if_rdata, m_data_if);
        check("dm_rdata", dm_rdata, m_data_dm);
        if (reset) begin
            done_if = 0; done_dm = 0;
            if (m_inflight && mem_ready) begin
                if (m_owner == 1) begin
                    done_if = 1; m_data_if = mem_rdata;
                end else begin
                    done_dm = 1;
                    if (!m_wr) m_data_dm = mem_rdata;
                end
                m_inflight = 0;
                if (m_owner == 1 && want_dm) begin
                    m_inflight = 1; m_owner = 2;
                    m_addr = dm_addr; m_wr = dm_wr; m_wdata = dm_wdata;
                end else if (m_owner == 2 && want_if) begin
                    m_inflight = 1; m_owner = 1;
                    m_addr = if_addr; m_wr = 0; m_wdata = '0;
                end
            end else if (!m_inflight) begin
                if (want_dm) begin
                    m_inflight = 1; m_owner = 2;
                    m_addr = dm_addr; m_wr = dm_wr; m_wdata = dm_wdata;
                end else if (want_if) begin
                    m_inflight = 1; m_owner = 1;
                    m_addr = if_addr; m_wr = 0; m_wdata = '0;
                end
            end
            if (done_if) m_served_if = 1; else if (!frz) m_served_if = 0;
            if (done_dm) m_served_dm = 1; else if (!frz) m_served_dm = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt_stall;
        int cnt_valid;
        int k;

        // reset values
        @(negedge clk);
        check("rst mem_valid", mem_valid, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst if_rdata", if_rdata, 0);
        check("rst dm_rdata", dm_rdata, 0);
        check("rst done", {if_done, dm_done}, 0);
        next_cycle();
        reset = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle valid", mem_valid, 0);
            check("idle stall", stall, 0);
            next_cycle();
        end

        // single fetch, 2 wait cycles
        if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
        cnt_stall = 0; cnt_valid = 0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 3);
            @(negedge clk);
            cnt_stall += int'(stall);
            cnt_valid += int'(mem_valid);
            if (i >= 1 && i <= 3) check("fetch addr", mem_addr, 32'h100);
            if (i == 4) begin
                check("fetch rdata", if_rdata, 32'hDEADBEEF);
                check("fetch done", if_done, 1);
            end
            next_cycle();
        end
        check("fetch stall cycles", cnt_stall, 4);
        check("fetch valid cycles", cnt_valid, 3);
        if_req = 1'b0;
        @(negedge clk);
        check("fetch done cleared", if_done, 0);
        next_cycle();

        // simultaneous load and fetch, ready tied high
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h2000;
        if_req = 1'b1; if_addr = 32'h104; mem_ready = 1'b1;
        cnt_stall = 0;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            cnt_stall += int'(stall);
            if (i == 1) check("both first", {mem_valid, mem_addr}, {1'b1, 32'h2000});
            if (i == 2) check("both second", {mem_valid, mem_addr}, {1'b1, 32'h104});
            if (i == 3) begin
                check("both stall low", stall, 0);
                check("both dm_rdata", dm_rdata, 32'hA000_0001);
                check("both if_rdata", if_rdata, 32'hA000_0002);
            end
            next_cycle();
        end
        check("both stall cycles", cnt_stall, 3);
        dm_req = 1'b0; if_req = 1'b0;

        // store
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h55;
        mem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("store mem_wr", mem_wr, (i == 1));
            if (i == 1) check("store fields", {mem_addr, mem_wdata}, {32'h40, 32'h55});
            if (i == 2) begin
                check("store done", dm_done, 1);
                check("store dm_rdata kept", dm_rdata, 32'hA000_0001);
                check("store if_rdata kept", if_rdata, 32'hA000_0002);
            end
            next_cycle();
        end
        dm_req = 1'b0; dm_wr = 1'b0;

        // address change during a waited load
        dm_req = 1'b1; dm_addr = 32'h300; mem_rdata = 32'h12345678;
        for (int i = 0; i < 6; i++) begin
            mem_ready = (i == 4);
            if (i == 2) dm_addr = 32'h3FC;
            @(negedge clk);
            if (i >= 1 && i <= 4) check("hold addr", {mem_valid, mem_addr}, {1'b1, 32'h300});
            if (i == 5) check("hold rdata", {dm_done, dm_rdata}, {1'b1, 32'h12345678});
            next_cycle();
        end
        dm_req = 1'b0; mem_ready = 1'b1;

        // back-to-back fetch-only pipeline cycles
        k = 0;
        if_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if_addr = 32'h200 + 32'(4 * k);
            mem_rdata = 32'hC000_0000 + 32'(i);
            @(negedge clk);
            check("b2b if_done", if_done, (i % 3 == 2));
            check("b2b stall", stall, (i % 3 != 2));
            if (i % 3 == 1) check("b2b addr", mem_addr, 32'h200 + 32'(4 * k));
            if (i % 3 == 2) check("b2b rdata", if_rdata, 32'hC000_0000 + 32'(i - 1));
            if (!stall) k++;
            next_cycle();
        end
        if_req = 1'b0;

        // reset asserted during a data transfer
        dm_req = 1'b1; dm_addr = 32'h500; mem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        check("pre-reset valid", mem_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("reset drops valid", mem_valid, 0);
        check("reset clears addr", mem_addr, 0);
        @(negedge clk);
        next_cycle();
        dm_req = 1'b0;
        reset = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
